// File: rtl/ex_mem_flag_stage.sv
// ============================================================================
// ex_mem_flag_stage
// ----------------------------------------------------------------------------
// Execute -> memory pipeline register for the 64-bit ALU.
//
// It holds one instruction behind a valid/ready handshake, carrying the ALU
// result, the destination register and its write enable. It also:
//   * keeps the architectural NZCV flag register, updated only by accepted
//     flag-setting instructions (ADDS/SUBS/ANDS-style);
//   * resolves B.cond / CBZ / CBNZ when the instruction is accepted and
//     registers the decision as branch_taken for the redirect logic.
//
// Ports
//   clk            in   1         clock, all state on the rising edge
//   reset_n        in   1         asynchronous active-low reset
//   in_valid       in   1         execute stage presents an instruction
//   in_ready       out  1         stage can take an instruction this cycle
//   alu_result     in   WIDTH     ALU result
//   alu_negative   in   1         ALU N flag
//   alu_zero       in   1         ALU Z flag
//   alu_overflow   in   1         ALU V flag
//   alu_carry_out  in   1         ALU C flag
//   alu_cntrl      in   3         ALU op (000 passB, 010 add, 011 sub,
//                                 100 and, 101 or, 110 xor)
//   set_flags      in   1         instruction updates NZCV
//   is_bcond       in   1         instruction is B.cond
//   cond           in   4         B.cond condition code (ARM encoding)
//   is_cbz         in   1         instruction is CBZ (Rt passed through ALU)
//   is_cbnz        in   1         instruction is CBNZ
//   rd             in   REG_BITS  destination register index
//   reg_write      in   1         instruction writes rd
//   flush          in   1         squash this stage at the next edge
//   out_valid      out  1         registered instruction available
//   out_ready      in   1         downstream takes out_* this cycle
//   out_result     out  WIDTH     registered ALU result
//   out_rd         out  REG_BITS  registered destination register
//   out_reg_write  out  1         registered write enable (0 when squashed)
//   branch_taken   out  1         registered branch decision, gated by out_valid
//   flags_nzcv     out  4         architectural flags {N,Z,C,V}
// ============================================================================
module ex_mem_flag_stage #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,

    // upstream handshake and payload
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_negative,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    input  logic                alu_carry_out,
    input  logic [2:0]          alu_cntrl,
    input  logic                set_flags,
    input  logic                is_bcond,
    input  logic [3:0]          cond,
    input  logic                is_cbz,
    input  logic                is_cbnz,
    input  logic [REG_BITS-1:0] rd,
    input  logic                reg_write,
    input  logic                flush,

    // downstream handshake and payload
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_reg_write,
    output logic                branch_taken,
    output logic [3:0]          flags_nzcv
);

    // ------------------------------------------------------------------
    // ALU operation codes that matter to this stage
    // ------------------------------------------------------------------
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // ------------------------------------------------------------------
    // Condition evaluation.
    // ARM condition codes come in pairs: cond[3:1] selects a base test and
    // cond[0] inverts it. The only exception is 1111, which is "always"
    // just like 1110 rather than "never".
    // ------------------------------------------------------------------
    function automatic logic cond_passed(input logic [3:0] cc,
                                         input logic [3:0] nzcv);
        logic n_f;
        logic z_f;
        logic c_f;
        logic v_f;
        logic base;
        logic res;
        n_f  = nzcv[3];
        z_f  = nzcv[2];
        c_f  = nzcv[1];
        v_f  = nzcv[0];
        base = 1'b1;
        case (cc[3:1])
            3'b000:  base = z_f;                        // EQ / NE
            3'b001:  base = c_f;                        // HS / LO
            3'b010:  base = n_f;                        // MI / PL
            3'b011:  base = v_f;                        // VS / VC
            3'b100:  base = c_f & ~z_f;                 // HI / LS
            3'b101:  base = (n_f == v_f);               // GE / LT
            3'b110:  base = ~z_f & (n_f == v_f);        // GT / LE
            default: base = 1'b1;                       // AL
        endcase
        if (cc[0] && (cc[3:1] != 3'b111)) begin
            res = ~base;
        end else begin
            res = base;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic                valid_q,     valid_d;
    logic [WIDTH-1:0]    result_q,    result_d;
    logic [REG_BITS-1:0] rd_q,        rd_d;
    logic                reg_write_q, reg_write_d;
    logic                branch_q,    branch_d;
    logic [3:0]          flags_q,     flags_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;

    // The slot is free when empty or when its occupant leaves this cycle.
    assign in_ready = ~valid_q | out_ready;
    // A flushed cycle never accepts, so a squashed instruction can neither
    // land in the register nor touch the flags.
    assign accept   = in_valid & in_ready & ~flush;

    // ------------------------------------------------------------------
    // Branch decision for the incoming instruction.
    // B.cond reads the flags as they stand before this edge: a flag-setter
    // ahead of it has already written flags_q at its own accept, so
    // back-to-back SUBS -> B.cond needs no bypass.
    // CBZ/CBNZ test the register value, which the ALU passes through, so
    // the ALU zero flag is exactly "Rt == 0".
    // ------------------------------------------------------------------
    logic branch_decision;

    always_comb begin
        branch_decision = 1'b0;
        if (is_bcond) begin
            branch_decision = cond_passed(cond, flags_q);
        end else if (is_cbz) begin
            branch_decision = alu_zero;
        end else if (is_cbnz) begin
            branch_decision = ~alu_zero;
        end
    end

    // ------------------------------------------------------------------
    // New flag value for a flag-setting instruction.
    // Logical ops define C and V as zero regardless of what the ALU drives
    // on those lines.
    // ------------------------------------------------------------------
    logic       logical_op;
    logic [3:0] new_flags;

    assign logical_op = (alu_cntrl == ALU_AND) |
                        (alu_cntrl == ALU_OR)  |
                        (alu_cntrl == ALU_XOR);

    assign new_flags = {alu_negative,
                        alu_zero,
                        alu_carry_out & ~logical_op,
                        alu_overflow  & ~logical_op};

    // ------------------------------------------------------------------
    // Next-state logic. Priority: flush, then accept, then drain; with
    // none of those the stage holds (stall or idle).
    // ------------------------------------------------------------------
    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        branch_d    = branch_q;
        flags_d     = flags_q;

        if (flush) begin
            // Result and rd are left as they were; with valid and
            // reg_write cleared they have no effect downstream.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            branch_d    = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            result_d    = alu_result;
            rd_d        = rd;
            reg_write_d = reg_write;
            branch_d    = branch_decision;
            if (set_flags) begin
                flags_d = new_flags;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            branch_q    <= branch_d;
            flags_q     <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. branch_taken is gated so a stale decision left behind in
    // an emptied slot can never redirect fetch.
    // ------------------------------------------------------------------
    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q;
    assign branch_taken  = branch_q & valid_q;
    assign flags_nzcv    = flags_q;

endmodule
